tinker_mem_responder: RTL

Multi-cycle, handshaked memory responder for the Tinker core: the memory end of the fetch and load/store interface. It serves one 32-bit instruction-fetch port and one 64-bit data port from a single byte-addressed, big-endian array. Each transaction has a fixed, parameterised latency, so the core can move from single-cycle combinational memory to a realistic multi-cycle memory. It sits beside `tinker_core`, replacing the combinational `memory` block on the core's memory side.

---
 rtl/tinker_pkg.sv | 38 +++
 rtl/mem_arbiter.sv | 22 ++
 rtl/tinker_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tinker_pkg.sv
// Shared Tinker types and constants: memory FSM states, port ids, request payload.
package tinker_pkg;

  localparam int unsigned TINKER_MEM_SIZE   = 524288;
  localparam logic [31:0] TINKER_RESET_PC   = 32'h2000;
  localparam logic [63:0] TINKER_STACK_INIT = 64'h10000;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned IDATA_W = 32;
  localparam int unsigned DDATA_W = 64;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } mem_port_t;

  typedef struct packed {
    mem_port_t            port;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [DDATA_W-1:0]   wdata;
  } mem_req_t;

  // True when [addr, addr+nbytes) fits in the array; 33-bit sum so addresses near 2^32 cannot wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input int unsigned nbytes,
                                    input int unsigned mem_size);
    return ({1'b0, addr} + 33'(nbytes)) <= 33'(mem_size);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter: the data port wins over instruction fetch.
module mem_arbiter
  import tinker_pkg::*;
(
  input  logic      idle,
  input  logic      if_req_valid,
  input  logic      d_req_valid,
  output logic      if_req_ready,
  output logic      d_req_ready,
  output logic      grant,
  output mem_port_t grant_port
);

  // Ready/grant are pure functions of idle and the two valids.
  always_comb begin
    d_req_ready  = idle;
    if_req_ready = idle && !d_req_valid;
    grant        = idle && (d_req_valid || if_req_valid);
    grant_port   = d_req_valid ? PORT_D : PORT_IF;
  end

endmodule

// File: rtl/tinker_mem_responder.sv
// Multi-cycle, fixed-latency big-endian memory serving a 32-bit fetch port and a 64-bit data port.
module tinker_mem_responder
  import tinker_pkg::*;
#(
  parameter int unsigned MEM_SIZE = TINKER_MEM_SIZE,
  parameter int unsigned LATENCY  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req_valid,
  input  logic [ADDR_W-1:0]  if_req_addr,
  output logic               if_req_ready,
  output logic               if_rsp_valid,
  output logic [IDATA_W-1:0] if_rsp_data,
  output logic               if_rsp_err,
  input  logic               d_req_valid,
  input  logic               d_req_we,
  input  logic [ADDR_W-1:0]  d_req_addr,
  input  logic [DDATA_W-1:0] d_req_wdata,
  output logic               d_req_ready,
  output logic               d_rsp_valid,
  output logic [DDATA_W-1:0] d_rsp_data,
  output logic               d_rsp_err
);

  localparam int unsigned      IDX_W    = $clog2(MEM_SIZE);
  // cnt holds the remaining BUSY cycles minus one, so BUSY lasts LATENCY-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  logic [7:0] bytes [0:MEM_SIZE-1];

  mem_state_t         state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               up;
  logic               idle;
  logic               grant;
  mem_port_t          grant_port;
  mem_req_t           hold, sel;
  logic               sel_ok_if, sel_ok_d, hold_ok_d;
  logic [IDATA_W-1:0] rd_if;
  logic [DDATA_W-1:0] rd_d;

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] base, input int unsigned k);
    return IDX_W'(base + ADDR_W'(k));
  endfunction

  // Ready only once a cycle has been sampled out of reset.
  assign idle = (state == IDLE) && up;

  mem_arbiter u_arb (
    .idle         (idle),
    .if_req_valid (if_req_valid),
    .d_req_valid  (d_req_valid),
    .if_req_ready (if_req_ready),
    .d_req_ready  (d_req_ready),
    .grant        (grant),
    .grant_port   (grant_port)
  );

  // Live request in the accept cycle (needed when LATENCY==1), latched copy afterwards.
  always_comb begin
    sel = hold;
    if (grant) begin
      sel.port  = grant_port;
      sel.we    = (grant_port == PORT_D) && d_req_we;
      sel.addr  = (grant_port == PORT_D) ? d_req_addr : if_req_addr;
      sel.wdata = d_req_wdata;
    end
  end

  assign sel_ok_if = in_range(sel.addr, 4, MEM_SIZE);
  assign sel_ok_d  = in_range(sel.addr, 8, MEM_SIZE);
  assign hold_ok_d = in_range(hold.addr, 8, MEM_SIZE);

  // Big-endian read of the selected address.
  always_comb begin
    rd_if = {bytes[idx(sel.addr, 0)], bytes[idx(sel.addr, 1)],
             bytes[idx(sel.addr, 2)], bytes[idx(sel.addr, 3)]};
    rd_d  = {rd_if,
             bytes[idx(sel.addr, 4)], bytes[idx(sel.addr, 5)],
             bytes[idx(sel.addr, 6)], bytes[idx(sel.addr, 7)]};
  end

  // State, countdown and out-of-reset flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      up    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      up    <= 1'b1;
    end
  end

  // Next state: IDLE -> BUSY (or RESP at LATENCY 1) -> RESP -> IDLE.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (grant) begin
          if (LATENCY == 1) begin
            next_state = RESP;
          end else begin
            next_state = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) next_state = RESP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch request fields at accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset)     hold <= '0;
    else if (grant) hold <= sel;
  end

  // Response registers: valid pulses for one cycle, data/err held until the next response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if (next_state == RESP) begin
        if (sel.port == PORT_D) begin
          d_rsp_valid <= 1'b1;
          d_rsp_err   <= !sel_ok_d;
          d_rsp_data  <= (sel_ok_d && !sel.we) ? rd_d : '0;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_err   <= !sel_ok_if;
          if_rsp_data  <= sel_ok_if ? rd_if : '0;
        end
      end
    end
  end

  // Store commit on the edge closing RESP; reset at that edge drops it.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && hold.port == PORT_D && hold.we && hold_ok_d) begin
      for (int i = 0; i < 8; i++) begin
        bytes[idx(hold.addr, i)] <= hold.wdata[8*(7-i) +: 8];
      end
    end
  end

endmodule
